// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that did not go last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = (last_owner == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else begin
      winner = req1 ? PORT_DMA : PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port fixed-latency memory between the CPU (port 0) and DMA (port 1)
// using round-robin arbitration with a req/done handshake.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_owner;

  logic              pick_valid;
  logic              pick_winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign sel_we    = (pick_winner == PORT_DMA) ? we1    : we0;
  assign sel_addr  = (pick_winner == PORT_DMA) ? addr1  : addr0;
  assign sel_wdata = (pick_winner == PORT_DMA) ? wdata1 : wdata0;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // sees pre-edge values; blocking ones would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= PORT_CPU;
      last_owner <= PORT_DMA;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_winner;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_read  <= ~sel_we;
            mem_write <= sel_we;
            gnt0      <= (pick_winner == PORT_CPU);
            gnt1      <= (pick_winner == PORT_DMA);
            cnt       <= CNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // mem_rdata is only valid in this last strobe cycle.
            if (mem_read) begin
              if (owner == PORT_CPU) rdata0 <= mem_rdata;
              else                   rdata1 <= mem_rdata;
            end
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            done0      <= (owner == PORT_CPU);
            done1      <= (owner == PORT_DMA);
            last_owner <= owner;
            state      <= DONE;
          end
        end
        DONE: begin
          // Requests are deliberately ignored here; a held req is taken as new in IDLE.
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (MEM_LAT=2 and MEM_LAT=1) against a timeline model.
module tb_mem_port_arbiter;

  localparam int M_MAN  = 0;
  localparam int M_RAND = 1;
  localparam int M_BUSY = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], req0[2], we0[2], req1[2], we1[2];
  logic [11:0] addr0[2], wdata0[2], addr1[2], wdata1[2], mem_rdata[2];
  logic        gnt0[2], done0[2], gnt1[2], done1[2], mem_read[2], mem_write[2];
  logic [11:0] rdata0[2], rdata1[2], mem_addr[2], mem_wdata[2];

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(2)) dut0 (
    .clk(clk), .rst(rst[0]),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .gnt0(gnt0[0]), .done0(done0[0]), .rdata0(rdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .gnt1(gnt1[0]), .done1(done1[0]), .rdata1(rdata1[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst[1]),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .gnt0(gnt0[1]), .done0(done0[1]), .rdata0(rdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .gnt1(gnt1[1]), .done1(done1[1]), .rdata1(rdata1[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Reference model: one in-flight access described by its age in cycles since grant.
  typedef struct {
    bit          active;
    bit          own;
    bit          we;
    logic [11:0] addr;
    logic [11:0] wdata;
    int          age;
    bit          last;
    logic [11:0] rd0;
    logic [11:0] rd1;
    logic [11:0] haddr;
    logic [11:0] hwdata;
  } mdl_t;

  mdl_t        m[2];
  bit          armed[2];
  logic [11:0] rdv[2];
  logic [11:0] mem[2][4096];
  bit          pend[2][2];
  int          mode[2][2];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic string tg(input int i, input string s);
    return $sformatf("u%0d_%s", i, s);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input int i, input int p, input logic r, input logic w,
                       input logic [11:0] a, input logic [11:0] d);
    if (p == 0) begin
      req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d;
    end else begin
      req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d;
    end
  endtask

  task automatic set_req(input int i, input int p, input logic r);
    if (p == 0) req0[i] = r;
    else        req1[i] = r;
  endtask

  task automatic start(input int i, input int p);
    drive(i, p, 1'b1, 1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom));
    pend[i][p] = 1'b1;
  endtask

  task automatic step(input int i);
    int lat;
    lat = lat_of(i);
    if (rst[i]) begin
      m[i].active = 0; m[i].own = 0; m[i].we = 0; m[i].age = 0; m[i].last = 1;
      m[i].rd0 = '0; m[i].rd1 = '0; m[i].haddr = '0; m[i].hwdata = '0;
      armed[i] = 1;
    end else if (m[i].active) begin
      if (m[i].age == lat + 1) begin
        m[i].active = 0;
      end else begin
        m[i].age++;
        if (m[i].age == lat + 1) begin
          m[i].last = m[i].own;
          if (m[i].we)          mem[i][m[i].addr] = m[i].wdata;
          else if (m[i].own)    m[i].rd1 = rdv[i];
          else                  m[i].rd0 = rdv[i];
        end
      end
    end else if (req0[i] || req1[i]) begin
      m[i].own    = (req0[i] && req1[i]) ? !m[i].last : req1[i];
      m[i].we     = m[i].own ? we1[i] : we0[i];
      m[i].addr   = m[i].own ? addr1[i] : addr0[i];
      m[i].wdata  = m[i].own ? wdata1[i] : wdata0[i];
      m[i].haddr  = m[i].addr;
      m[i].hwdata = m[i].wdata;
      m[i].age    = 1;
      m[i].active = 1;
    end
  endtask

  task automatic check_outputs(input int i);
    bit s, dn;
    s  = m[i].active && m[i].age <= lat_of(i);
    dn = m[i].active && m[i].age == lat_of(i) + 1;
    check(tg(i, "gnt0"), gnt0[i], m[i].active && !m[i].own);
    check(tg(i, "gnt1"), gnt1[i], m[i].active && m[i].own);
    check(tg(i, "done0"), done0[i], dn && !m[i].own);
    check(tg(i, "done1"), done1[i], dn && m[i].own);
    check(tg(i, "mem_read"), mem_read[i], s && !m[i].we);
    check(tg(i, "mem_write"), mem_write[i], s && m[i].we);
    check(tg(i, "mem_addr"), mem_addr[i], m[i].haddr);
    check(tg(i, "mem_wdata"), mem_wdata[i], m[i].hwdata);
    check(tg(i, "rdata0"), rdata0[i], m[i].rd0);
    check(tg(i, "rdata1"), rdata1[i], m[i].rd1);
    check(tg(i, "gnt_excl"), gnt0[i] & gnt1[i], 0);
    check(tg(i, "strobe_excl"), mem_read[i] & mem_write[i], 0);
  endtask

  // Advance one clock: predict the edge, then sample outputs mid-cycle.
  task automatic tick();
    for (int i = 0; i < 2; i++) step(i);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (armed[i]) check_outputs(i);
      if (m[i].active && !m[i].we && m[i].age == lat_of(i)) rdv[i] = mem[i][m[i].addr];
      else                                                  rdv[i] = 12'($urandom);
      mem_rdata[i] = rdv[i];
    end
  endtask

  task automatic agent(input int i);
    for (int p = 0; p < 2; p++) begin
      bit dn, gr;
      dn = m[i].active && m[i].age == lat_of(i) + 1 && m[i].own == 1'(p);
      gr = m[i].active && m[i].age <= lat_of(i) && m[i].own == 1'(p);
      if (mode[i][p] == M_BUSY) begin
        if (dn || !pend[i][p]) start(i, p);
      end else if (mode[i][p] == M_RAND) begin
        if (dn) begin
          pend[i][p] = 0;
          set_req(i, p, 1'b0);
          if ($urandom_range(0, 1) == 1) start(i, p);
        end else if (!pend[i][p]) begin
          if ($urandom_range(0, 2) == 0) start(i, p);
        end else if (gr) begin
          if ($urandom_range(0, 7) == 0) set_req(i, p, 1'b0);
          if ($urandom_range(0, 3) == 0)
            drive(i, p, (p == 0) ? req0[i] : req1[i], 1'($urandom_range(0, 1)),
                  12'($urandom), 12'($urandom));
        end
      end
    end
  endtask

  task automatic assert_reset(input int i);
    rst[i] = 1'b1;
    pend[i][0] = 0;
    pend[i][1] = 0;
    drive(i, 0, 1'b0, 1'b0, '0, '0);
    drive(i, 1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int own_q[$];
    int rise1[$];
    bit pg0[2], pg1[2];

    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 4096; a++) mem[i][a] = 12'($urandom);
      mode[i][0] = M_MAN; mode[i][1] = M_MAN;
      armed[i] = 0;
      rdv[i] = '0;
      mem_rdata[i] = '0;
      assert_reset(i);
    end

    tick();
    tick();
    check("reset_gnt0", gnt0[0], 0);
    check("reset_mem_read", mem_read[0], 0);
    check("reset_mem_addr", mem_addr[0], 0);
    check("reset_rdata0", rdata0[0], 0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // CPU read, MEM_LAT=2
    mem[0][12'o0100] = 12'o7421;
    drive(0, 0, 1'b1, 1'b0, 12'o0100, 12'o0000);
    tick();
    check("rd_strobe1", mem_read[0], 1);
    check("rd_addr", mem_addr[0], 12'o0100);
    check("rd_gnt0", gnt0[0], 1);
    tick();
    check("rd_strobe2", mem_read[0], 1);
    tick();
    check("rd_strobe_off", mem_read[0], 0);
    check("rd_done0", done0[0], 1);
    check("rd_rdata0", rdata0[0], 12'o7421);
    drive(0, 0, 1'b0, 1'b0, 12'o0100, 12'o0000);
    tick();
    check("rd_done0_once", done0[0], 0);

    // DMA write
    drive(0, 1, 1'b1, 1'b1, 12'o0200, 12'o1234);
    tick();
    check("wr_strobe1", mem_write[0], 1);
    check("wr_wdata", mem_wdata[0], 12'o1234);
    check("wr_no_read", mem_read[0], 0);
    tick();
    check("wr_strobe2", mem_write[0], 1);
    tick();
    check("wr_done1", done1[0], 1);
    check("wr_rdata1_kept", rdata1[0], 0);
    check("wr_rdata0_kept", rdata0[0], 12'o7421);
    drive(0, 1, 1'b0, 1'b1, 12'o0200, 12'o1234);
    tick();
    check("wr_done1_once", done1[0], 0);

    // req dropped after grant, address changed
    drive(0, 0, 1'b1, 1'b0, 12'o0100, 12'o0000);
    tick();
    drive(0, 0, 1'b0, 1'b0, 12'o0777, 12'o0000);
    tick();
    check("drop_addr_latched", mem_addr[0], 12'o0100);
    check("drop_strobe", mem_read[0], 1);
    tick();
    check("drop_done0", done0[0], 1);
    check("drop_rdata0", rdata0[0], 12'o7421);
    tick();

    // reset during the second BUSY cycle of a write, req held through reset
    drive(0, 0, 1'b1, 1'b1, 12'o0300, 12'o5555);
    tick();
    tick();
    rst[0] = 1'b1;
    tick();
    check("abort_gnt0", gnt0[0], 0);
    check("abort_mem_write", mem_write[0], 0);
    check("abort_mem_addr", mem_addr[0], 0);
    check("abort_mem_wdata", mem_wdata[0], 0);
    check("abort_rdata0", rdata0[0], 0);
    rst[0] = 1'b0;
    tick();
    check("regrant_gnt0", gnt0[0], 1);
    check("regrant_addr", mem_addr[0], 12'o0300);
    tick();
    tick();
    check("regrant_done0", done0[0], 1);
    drive(0, 0, 1'b0, 1'b0, 12'o0000, 12'o0000);
    tick();

    // Continuous requests: alternation on unit 0, single-port spacing on unit 1
    assert_reset(0);
    assert_reset(1);
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    mode[0][0] = M_BUSY; mode[0][1] = M_BUSY;
    mode[1][0] = M_BUSY; mode[1][1] = M_MAN;
    agent(0);
    agent(1);
    pg0[0] = 0; pg1[0] = 0; pg0[1] = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (gnt0[0] && !pg0[0]) own_q.push_back(0);
      if (gnt1[0] && !pg1[0]) own_q.push_back(1);
      if (gnt0[1] && !pg0[1]) rise1.push_back(cyc);
      pg0[0] = gnt0[0]; pg1[0] = gnt1[0]; pg0[1] = gnt0[1];
      agent(0);
      agent(1);
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_order_%0d", k), (k < own_q.size()) ? own_q[k] : 99, k % 2);
    for (int k = 1; k < 4; k++)
      check($sformatf("lat1_spacing_%0d", k),
            (k < rise1.size()) ? rise1[k] - rise1[k-1] : 99, 3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2; i++) begin
      mode[i][0] = M_RAND; mode[i][1] = M_RAND;
    end
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) begin
          rst[i] = 1'b0;
          agent(i);
        end else if ($urandom_range(0, 399) == 0) begin
          assert_reset(i);
        end else begin
          agent(i);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port memory between two requesters: the CPU datapath (port 0, driven by the control unit's fetch/operand/store cycles) and an I/O DMA engine (port 1).
- Uses round-robin arbitration with a req/done handshake.
- Drives memory strobes for a fixed-latency access and returns read data to the winning port.
- Sits between the control unit/datapath and the memory block.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 12, memory word width.
- MEM_LAT, 2, cycles mem_read/mem_write are held per access. Legal range is 1..15; an illegal value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  CPU access request. Held high until done0.
- we0  in  1  CPU access type: 1 = write, 0 = read.
- addr0  in  ADDR_W  CPU address.
- wdata0  in  DATA_W  CPU write data.
- gnt0  out  1  CPU owns the memory (level).
- done0  out  1  one-cycle pulse marking CPU access complete.
- rdata0  out  DATA_W  CPU read data; valid from the done0 cycle until the next CPU read completes.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1  same as above for the DMA port.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the final cycle of mem_read.

Behaviour:
- All outputs are registered.
- Reset: state IDLE, last_owner = 1 (CPU wins the first tie), cnt = 0. All strobes, gnt, done, mem_addr, mem_wdata, rdata0 and rdata1 are 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that port wins.
  - Both reqs: the port that is not last_owner wins.
  - On the clock edge: latch owner, addr, we, wdata; set gnt_owner = 1; set mem_read = ~we or mem_write = we; cnt = MEM_LAT-1; go to BUSY.
- BUSY:
  - Strobes, mem_addr and mem_wdata are held constant.
  - cnt>0: decrement cnt.
  - cnt==0: if read, capture mem_rdata into rdata_owner. Drop the strobes, pulse done_owner, set last_owner = owner, go to DONE.
- DONE:
  - done_owner = 1 for this single cycle; gnt_owner stays 1.
  - Next edge: clear gnt and done and return to IDLE unconditionally. Requests are not sampled in DONE.
- Latency: req sampled at edge k → strobes high on cycles k+1 .. k+MEM_LAT → done on cycle k+1+MEM_LAT.
- Minimum request-to-request spacing on one port is MEM_LAT+2 cycles.
- A requester deasserts req (or presents a new access) the cycle after done. A req still high in the cycle after DONE is treated as a new request.
- Writes leave rdata unchanged. The non-owner's rdata is never disturbed.
- req dropped mid-BUSY: the access still completes and done still pulses. Addr/we/wdata changes after grant are ignored because they are latched.
- rst asserted in BUSY or DONE: abort. Reset values apply on the next edge. A write in progress may be partial; the memory contents are not guaranteed.
- gnt0 & gnt1 is never 1. mem_read & mem_write is never 1.
- No starvation: with both ports requesting continuously, grants alternate strictly.

Decomposition:
- Shared package (mem_arb_pkg):
  - state encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - port index constants PORT_CPU=1'b0, PORT_DMA=1'b1.
- Sub-module rr_pick2: combinational 2-way round-robin picker (inputs req0, req1, last_owner; outputs valid, winner). It is reusable for a later interrupt/I/O arbiter.
- The FSM, latency counter and latches stay in the top module.

Test Plan:
- CPU read: MEM_LAT=2, req0=1, we0=0, addr0=12'o0100, memory model returns 12'o7421 → mem_read high exactly 2 cycles with mem_addr=12'o0100, done0 pulse on cycle k+3, rdata0=12'o7421, gnt1 never high.
- DMA write: req1=1, we1=1, addr1=12'o0200, wdata1=12'o1234 → mem_write high 2 cycles, mem_wdata=12'o1234, done1 pulse once, rdata1 unchanged, mem_read stays 0.
- Simultaneous requests held continuously after reset → grant order CPU, DMA, CPU, DMA. Each done pulses once per access, and gnt0 and gnt1 are never both high.
- req0 dropped 1 cycle after grant and addr0 changed to 12'o0777 → access completes at the original addr 12'o0100 and done0 still pulses.
- rst asserted during the 2nd BUSY cycle of a write → next cycle all outputs 0 and state IDLE. A req held through reset is re-granted 1 cycle after rst deasserts.
- MEM_LAT=1 sweep with alternating reqs → strobes last 1 cycle, done at k+2, and the back-to-back same-port spacing is 3 cycles.
